// File: rtl/shift_tx_pkg.sv
// Shared state encoding and width helper for the framed serial transmitter.
package shift_tx_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_START  = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_PARITY = 3'd4;
  localparam logic [2:0] ST_STOP   = 3'd5;

  // Counter width able to hold 0..n; gives DIV_W from CLK_DIV and BIT_W from DATA_WIDTH.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/shift_tx_sequencer_bit_timer.sv
// Bit-period divider: counts CLK_DIV cycles and flags the last cycle of each period.
module bit_timer #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic period_end
);
  import shift_tx_pkg::*;

  localparam int DIV_W = cnt_width(CLK_DIV);

  logic [DIV_W-1:0] cnt;

  assign period_end = enable && (cnt == DIV_W'(CLK_DIV - 1));

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= period_end ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/shift_tx_sequencer.sv
// Sequences an external 8-bit shift register as a framed serial transmitter:
// start bit, data LSB first, optional even parity, stop bit.
module shift_tx_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 4,
  parameter int PARITY_EN  = 0
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [DATA_WIDTH-1:0] TxData,
  input  logic                  TxValid,
  output logic                  TxReady,
  output logic                  SrLoad,
  output logic [DATA_WIDTH-1:0] SrLoadIn,
  output logic                  SrShift,
  input  logic                  SrOut,
  output logic                  TxLine,
  output logic                  Busy,
  output logic                  Done
);
  import shift_tx_pkg::*;

  localparam int BIT_W = cnt_width(DATA_WIDTH);

  logic [2:0]            state;
  logic [2:0]            state_next;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  parity_q;
  logic [BIT_W-1:0]      bit_cnt;
  logic                  tx_line_q;
  logic                  line_next;
  logic                  period_end;
  logic                  accept;
  logic                  last_bit;
  logic                  timer_clear;

  assign accept      = TxValid && (state == ST_IDLE);
  assign last_bit    = (bit_cnt == BIT_W'(DATA_WIDTH - 1));
  assign timer_clear = (state == ST_IDLE) || (state == ST_LOAD);

  bit_timer #(.CLK_DIV(CLK_DIV)) u_bit_timer (
    .clk        (Clk),
    .rst_n      (Reset),
    .clear      (timer_clear),
    .enable     (!timer_clear),
    .period_end (period_end)
  );

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (accept) state_next = ST_LOAD;
      ST_LOAD:   state_next = ST_START;
      ST_START:  if (period_end) state_next = ST_DATA;
      ST_DATA:   if (period_end && last_bit)
                   state_next = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (period_end) state_next = ST_STOP;
      ST_STOP:   if (period_end) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Line level for the state being entered, so the framing bits appear registered.
  always_comb begin
    line_next = 1'b1;
    case (state_next)
      ST_START:  line_next = 1'b0;
      ST_PARITY: line_next = parity_q;
      default:   line_next = 1'b1;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state     <= ST_IDLE;
      data_q    <= '0;
      parity_q  <= 1'b0;
      bit_cnt   <= '0;
      tx_line_q <= 1'b1;
    end else begin
      state     <= state_next;
      tx_line_q <= line_next;
      if (accept) begin
        data_q   <= TxData;
        parity_q <= ^TxData;
      end
      if ((state == ST_DATA) && period_end) begin
        bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
      end
    end
  end

  assign TxReady  = (state == ST_IDLE);
  assign Busy     = (state != ST_IDLE);
  assign SrLoad   = (state == ST_LOAD);
  assign SrLoadIn = SrLoad ? data_q : '0;
  assign SrShift  = (state == ST_DATA) && period_end;
  assign Done     = (state == ST_STOP) && period_end;
  // Data bits come straight from the shift register's output flop, which already
  // holds the next bit on the cycle after each shift.
  assign TxLine   = (state == ST_DATA) ? SrOut : tx_line_q;

endmodule
